// File: rtl/di_latency_terminal.sv
// di_latency_terminal: di-bus endpoint with NUM_CH auto-incrementing counter
// channels. Each channel stalls the host via rdwr_ready for a programmable
// number of cycles. Wait, count and unmapped registers complete with no stall.
// The read data bus is forced to zero for other endpoints, so several
// terminals can share one OR-combined bus.
module di_latency_terminal #(
    parameter logic [15:0] EP_ADDR      = 16'h0000,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned WAIT_BITS    = 4,
    parameter int unsigned DEFAULT_WAIT = 7
) (
    input  logic        if_clock,
    input  logic        resetb,
    input  logic        diReset,
    input  logic [15:0] diEpAddr,
    input  logic [15:0] diRegAddr,
    input  logic [15:0] diRegDataIn,
    input  logic        diWrite,
    input  logic        diRead,
    output logic [15:0] diRegDataOut,
    output logic        rdwr_ready
);

    localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [15:0] CH_END   = 16'(NUM_CH);
    localparam logic [15:0] WAIT_END = 16'(2 * NUM_CH);
    localparam logic [15:0] CNT_ADDR = WAIT_END;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    state_t                  state_q;
    logic                    rdy_q;
    logic [15:0]             txn_q;
    logic [WAIT_BITS-1:0]    wcnt_q;
    logic [CH_W-1:0]         ch_q;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   count_q [NUM_CH];
    logic [DATA_WIDTH-1:0]   hold_q  [NUM_CH];
    logic [WAIT_BITS-1:0]    wait_q  [NUM_CH];

    logic [15:0]             txn_d;
    logic [WAIT_BITS-1:0]    wcnt_d;

    logic                    ep_hit;
    logic                    strobe;
    logic                    is_chan;
    logic                    is_wait;
    logic                    is_cnt;
    logic [CH_W-1:0]         chan_idx;
    logic [CH_W-1:0]         wait_idx;

    // Address decode of the live bus and next values of the free-running counters
    always_comb begin
        ep_hit   = (diEpAddr == EP_ADDR);
        strobe   = ep_hit && (diRead || diWrite);
        is_chan  = (diRegAddr < CH_END);
        is_wait  = (diRegAddr >= CH_END) && (diRegAddr < WAIT_END);
        is_cnt   = (diRegAddr == CNT_ADDR);
        chan_idx = CH_W'(diRegAddr);
        wait_idx = CH_W'(diRegAddr - CH_END);
        txn_d    = txn_q + 16'd1;
        wcnt_d   = wcnt_q + WAIT_BITS'(1);
    end

    // Read mux: zero unless this endpoint is addressed at a mapped register
    always_comb begin
        diRegDataOut = '0;
        if (ep_hit) begin
            if (is_chan) begin
                diRegDataOut = 16'(hold_q[chan_idx]);
            end else if (is_wait) begin
                diRegDataOut = 16'(wait_q[wait_idx]);
            end else if (is_cnt) begin
                diRegDataOut = txn_q;
            end
        end
    end

    // Transaction FSM: accept in IDLE, stall in WAIT, commit counter update on completion
    always_ff @(posedge if_clock) begin
        if (!resetb || diReset) begin
            state_q <= ST_IDLE;
            rdy_q   <= 1'b0;
            txn_q   <= '0;
            wcnt_q  <= '0;
            ch_q    <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                count_q[i] <= '0;
                hold_q[i]  <= '0;
                // the soft reset keeps the programmed wait settings
                if (!resetb) begin
                    wait_q[i] <= WAIT_BITS'(DEFAULT_WAIT);
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rdy_q <= 1'b1;
                    if (strobe) begin
                        if (is_chan) begin
                            // snapshot the request so later bus changes cannot disturb it
                            ch_q    <= chan_idx;
                            wr_q    <= diWrite;
                            wdata_q <= DATA_WIDTH'(diRegDataIn);
                            wcnt_q  <= '0;
                            state_q <= ST_WAIT;
                            rdy_q   <= 1'b0;
                        end else if (is_wait) begin
                            if (diWrite) begin
                                wait_q[wait_idx] <= WAIT_BITS'(diRegDataIn);
                            end
                            txn_q <= txn_d;
                        end else if (is_cnt) begin
                            txn_q <= txn_d;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == wait_q[ch_q]) begin
                        if (wr_q) begin
                            count_q[ch_q] <= wdata_q;
                        end else begin
                            hold_q[ch_q]  <= count_q[ch_q];
                            count_q[ch_q] <= count_q[ch_q] + DATA_WIDTH'(1);
                        end
                        txn_q   <= txn_d;
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end else begin
                        wcnt_q <= wcnt_d;
                    end
                end
            endcase
        end
    end

    assign rdwr_ready = rdy_q;

endmodule

// File: tb/tb_di_latency_terminal.sv
// Scoreboard bench for di_latency_terminal: channel transactions push their
// expected latency/data; an independent monitor measures each stall on
// rdwr_ready and checks the read data at completion.
module tb_di_latency_terminal;

    logic        if_clock    = 1'b0;
    logic        resetb      = 1'b0;
    logic        diReset     = 1'b0;
    logic [15:0] diEpAddr    = '0;
    logic [15:0] diRegAddr   = '0;
    logic [15:0] diRegDataIn = '0;
    logic        diWrite     = 1'b0;
    logic        diRead      = 1'b0;
    logic [15:0] diRegDataOut;
    logic        rdwr_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_read;
        logic [15:0] data;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];

    always #5 if_clock = ~if_clock;

    di_latency_terminal #(
        .EP_ADDR      (16'h0000),
        .NUM_CH       (4),
        .DATA_WIDTH   (16),
        .WAIT_BITS    (4),
        .DEFAULT_WAIT (7)
    ) dut (
        .if_clock     (if_clock),
        .resetb       (resetb),
        .diReset      (diReset),
        .diEpAddr     (diEpAddr),
        .diRegAddr    (diRegAddr),
        .diRegDataIn  (diRegDataIn),
        .diWrite      (diWrite),
        .diRead       (diRead),
        .diRegDataOut (diRegDataOut),
        .rdwr_ready   (rdwr_ready)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: measures each stall and compares against the scoreboard head
    initial begin : monitor
        bit   busy = 1'b0;
        int   low  = 0;
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge if_clock);
            if (!resetb || diReset) begin
                busy = 1'b0;
                low  = 0;
            end else if (busy) begin
                if (!rdwr_ready) begin
                    low++;
                end else begin
                    busy = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got stall of %0d cycles expected none", low);
                    end else begin
                        e = sb.pop_front();
                        check({e.name, "_lat"}, 16'(low), 16'(e.lat));
                        if (e.is_read) begin
                            check({e.name, "_data"}, diRegDataOut, e.data);
                        end
                    end
                end
            end else if (prev && !rdwr_ready) begin
                busy = 1'b1;
                low  = 1;
            end
            prev = rdwr_ready;
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!rdwr_ready && n < 40) begin
            @(posedge if_clock); #1;
            n++;
        end
        if (!rdwr_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: rdwr_ready got 0 expected 1", name);
        end
        @(negedge if_clock); #1;
    endtask

    // Counter-channel transaction; drives the strobe for exactly one edge
    task automatic chan_op(input string name, input int ch, input bit rd, input bit wr,
                           input logic [15:0] wdata, input logic [15:0] exp, input int lat,
                           input bit push);
        exp_t e;
        if (push) begin
            e.is_read = rd && !wr;
            e.data    = exp;
            e.lat     = lat;
            e.name    = name;
            sb.push_back(e);
        end
        diEpAddr    = 16'h0000;
        diRegAddr   = 16'(ch);
        diRegDataIn = wdata;
        diRead      = rd;
        diWrite     = wr;
        @(posedge if_clock); #1;
        diRead  = 1'b0;
        diWrite = 1'b0;
        if (push) wait_ready(name);
    endtask

    // Strobe that must complete without any stall
    task automatic zl_strobe(input string name, input logic [15:0] ep, input logic [15:0] addr,
                             input bit rd, input bit wr, input logic [15:0] wdata);
        diEpAddr    = ep;
        diRegAddr   = addr;
        diRegDataIn = wdata;
        diRead      = rd;
        diWrite     = wr;
        @(posedge if_clock); #1;
        diRead  = 1'b0;
        diWrite = 1'b0;
        @(negedge if_clock);
        check({name, "_ready"}, 16'(rdwr_ready), 16'h0001);
        #1;
    endtask

    task automatic peek(input string name, input logic [15:0] ep, input logic [15:0] addr,
                        input logic [15:0] exp);
        diEpAddr  = ep;
        diRegAddr = addr;
        #1;
        check(name, diRegDataOut, exp);
    endtask

    task automatic hard_reset();
        resetb    = 1'b0;
        diRegAddr = 16'h0000;
        diEpAddr  = 16'h0000;
        repeat (3) @(posedge if_clock);
        #1;
        check("hrst_ready_low", 16'(rdwr_ready), 16'h0000);
        check("hrst_data", diRegDataOut, 16'h0000);
        resetb = 1'b1;
        @(posedge if_clock); #1;
        check("hrst_ready_high", 16'(rdwr_ready), 16'h0001);
        @(negedge if_clock); #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stimulus
        int n;
        hard_reset();

        // default wait 7 -> 8-cycle stall
        chan_op("rd_ch0_a", 0, 1, 0, 16'h0, 16'h0000, 8, 1);
        chan_op("rd_ch0_b", 0, 1, 0, 16'h0, 16'h0001, 8, 1);
        peek("txn_after_2", 16'h0000, 16'd8, 16'd2);
        zl_strobe("rd_txn", 16'h0000, 16'd8, 1, 0, 16'h0);
        peek("txn_after_3", 16'h0000, 16'd8, 16'd3);

        // wait[2]=0 -> one-cycle stalls, back-to-back
        zl_strobe("wr_wait2", 16'h0000, 16'd6, 0, 1, 16'h0000);
        peek("wait2_val", 16'h0000, 16'd6, 16'h0000);
        chan_op("rd_ch2_a", 2, 1, 0, 16'h0, 16'h0000, 1, 1);
        chan_op("rd_ch2_b", 2, 1, 0, 16'h0, 16'h0001, 1, 1);
        chan_op("rd_ch2_c", 2, 1, 0, 16'h0, 16'h0002, 1, 1);

        // counter wrap
        chan_op("wr_ch1", 1, 0, 1, 16'hFFFF, 16'h0000, 8, 1);
        chan_op("rd_ch1_a", 1, 1, 0, 16'h0, 16'hFFFF, 8, 1);
        chan_op("rd_ch1_b", 1, 1, 0, 16'h0, 16'h0000, 8, 1);

        // strobes and bus changes during a ch3 stall are ignored
        sb.push_back('{1'b1, 16'h0000, 8, "rd_ch3_inflight"});
        diEpAddr  = 16'h0000;
        diRegAddr = 16'd3;
        diRead    = 1'b1;
        @(posedge if_clock); #1;
        diRead = 1'b0;
        @(posedge if_clock); #1;
        diRegAddr = 16'd0;
        diRead    = 1'b1;
        @(posedge if_clock); #1;
        diRead      = 1'b0;
        diRegAddr   = 16'd5;
        diRegDataIn = 16'h000A;
        diWrite     = 1'b1;
        @(posedge if_clock); #1;
        diWrite   = 1'b0;
        diRegAddr = 16'd3;
        wait_ready("rd_ch3_inflight");
        peek("wait1_untouched", 16'h0000, 16'd5, 16'd7);
        chan_op("rd_ch0_c", 0, 1, 0, 16'h0, 16'h0002, 8, 1);
        peek("txn_after_12", 16'h0000, 16'd8, 16'd12);

        // soft reset mid-stall keeps wait settings
        zl_strobe("wr_wait1", 16'h0000, 16'd5, 0, 1, 16'd5);
        peek("wait1_val", 16'h0000, 16'd5, 16'd5);
        chan_op("rd_ch1_abort", 1, 1, 0, 16'h0, 16'h0000, 0, 0);
        repeat (2) @(posedge if_clock);
        #1;
        diReset = 1'b1;
        @(posedge if_clock); #1;
        check("srst_ready_low", 16'(rdwr_ready), 16'h0000);
        @(posedge if_clock); #1;
        diReset = 1'b0;
        @(posedge if_clock); #1;
        check("srst_ready_high", 16'(rdwr_ready), 16'h0001);
        @(negedge if_clock); #1;
        peek("srst_wait1", 16'h0000, 16'd5, 16'd5);
        peek("srst_txn", 16'h0000, 16'd8, 16'd0);
        peek("srst_hold1", 16'h0000, 16'd1, 16'd0);
        chan_op("rd_ch1_srst", 1, 1, 0, 16'h0, 16'h0000, 6, 1);

        // hard reset mid-stall restores defaults
        chan_op("rd_ch1_abort2", 1, 1, 0, 16'h0, 16'h0000, 0, 0);
        @(posedge if_clock); #1;
        hard_reset();
        peek("hrst_wait1", 16'h0000, 16'd5, 16'd7);
        peek("hrst_txn", 16'h0000, 16'd8, 16'd0);
        peek("hrst_hold1", 16'h0000, 16'd1, 16'd0);
        chan_op("rd_ch1_hrst", 1, 1, 0, 16'h0, 16'h0000, 8, 1);

        // other endpoint: no response, no state change
        zl_strobe("other_ep_rd", 16'h0001, 16'd0, 1, 0, 16'h0);
        peek("other_ep_data", 16'h0001, 16'd0, 16'h0000);
        peek("other_ep_txn", 16'h0001, 16'd8, 16'h0000);
        chan_op("rd_ch0_after_ep", 0, 1, 0, 16'h0, 16'h0000, 8, 1);

        // unmapped address
        zl_strobe("unmapped_rd", 16'h0000, 16'd9, 1, 0, 16'h0);
        zl_strobe("unmapped_wr", 16'h0000, 16'd9, 0, 1, 16'h5555);
        peek("unmapped_data", 16'h0000, 16'd9, 16'h0000);
        peek("txn_after_unmapped", 16'h0000, 16'd8, 16'd2);

        // write wins when both strobes are high
        chan_op("rdwr_ch2", 2, 1, 1, 16'h1234, 16'h0000, 8, 1);
        chan_op("rd_ch2_after_wr", 2, 1, 0, 16'h0, 16'h1234, 8, 1);
        peek("txn_after_ww", 16'h0000, 16'd8, 16'd4);

        // maximum wait setting
        zl_strobe("wr_wait3_max", 16'h0000, 16'd7, 0, 1, 16'h000F);
        chan_op("rd_ch3_max", 3, 1, 0, 16'h0, 16'h0000, 16, 1);
        peek("txn_final", 16'h0000, 16'd8, 16'd6);

        n = 0;
        while (sb.size() > 0 && n < 50) begin
            @(negedge if_clock);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/di_latency_terminal.md
# di_latency_terminal

Parametrised device-interface (di) terminal for simulation and bring-up. It sits behind HostInterface on the di bus and implements NUM_CH auto-incrementing counter channels at one endpoint. Each channel has its own run-time-programmable wait latency, signalled through the rdwr_ready handshake. It exercises host-side stall handling across many channels, adds write-load and transaction counting, and returns zero data for any other endpoint so its output can be OR-combined.

## Interface
- EP_ADDR, 16'h0000: endpoint address this block answers on.
- NUM_CH, 4: counter channels; legal 1..64.
- DATA_WIDTH, 16: counter/data width; legal 1..16, zero-extended onto the 16-bit bus.
- WAIT_BITS, 4: width of per-channel wait setting (max wait 2^WAIT_BITS-1).
- DEFAULT_WAIT, 7: reset value of every wait setting.

- if_clock  in  1  clock; all state updates on rising edge.
- resetb  in  1  reset, synchronous, active-low.
- diReset  in  1  synchronous soft reset from HostInterface, active-high.
- diEpAddr  in  16  endpoint address.
- diRegAddr  in  16  register address within endpoint.
- diRegDataIn  in  16  write data.
- diWrite  in  1  write strobe.
- diRead  in  1  read strobe.
- diRegDataOut  out  16  read data; 0 when diEpAddr != EP_ADDR.
- rdwr_ready  out  1  high = terminal idle / transaction complete.

## Operation
- Register map (diRegAddr, when diEpAddr == EP_ADDR):
  - 0..NUM_CH-1: counter channel c.
  - NUM_CH..2*NUM_CH-1: wait setting of channel c (low WAIT_BITS bits).
  - 2*NUM_CH: transaction count, 16-bit, read-only.
  - Higher addresses: read 0, writes ignored.
- FSM states: IDLE, WAIT.
- IDLE, strobe to a counter channel:
  - Latch channel index, operation (write wins if diRead and diWrite are both high) and write data.
  - Clear wait counter; go to WAIT; rdwr_ready <= 0.
- WAIT:
  - If wait counter == latched channel's wait setting: complete the operation and return to IDLE with rdwr_ready <= 1.
  - Otherwise increment the wait counter.
- Completion:
  - Read: hold[c] <= count[c], then count[c] <= count[c]+1 (wraps modulo 2^DATA_WIDTH).
  - Write: count[c] <= diRegDataIn[DATA_WIDTH-1:0] and hold[c] unchanged.
  - Both: transaction count +1 (wraps at 16'hFFFF).
- IDLE, strobe to a wait register, count register or unmapped address:
  - Zero-latency; rdwr_ready stays 1.
  - A wait-register write takes effect at the next edge.
  - Transaction count +1 for mapped addresses only.
- Strobes for other endpoints are ignored. Strobes while in WAIT are ignored (no queueing). Changes to diEpAddr, diRegAddr or diRegDataIn during WAIT do not affect the in-flight transaction.
- diRegDataOut, combinational from the current address:
  - Channel c: hold[c].
  - Wait register: zero-extended wait setting.
  - Count register: transaction count.
  - Otherwise: 0.
- Reset (resetb low, or diReset high), mid-transaction included:
  - State IDLE; in-flight transaction abandoned with no counter update.
  - count, hold and transaction count = 0; rdwr_ready = 0 during reset.
  - resetb additionally restores all waits to DEFAULT_WAIT; diReset keeps them.
  - After reset: rdwr_ready = 1 on the first non-reset edge.

## Timing
- Strobe sampled at edge E (IDLE, counter channel, wait W): rdwr_ready low after E, high again after edge E+W+1.
- Ready is therefore low for exactly W+1 cycles; W=0 gives a one-cycle stall.
- Read data is valid when rdwr_ready is high after completion, and stays stable until the next completion on that channel.
- A new strobe is accepted at the first edge in which rdwr_ready is high after completion, i.e. back-to-back with no idle cycle needed.
- Wait-setting changes never affect an in-flight transaction; the setting is sampled against the latched index each cycle, and writes to wait registers are only accepted in IDLE.

## Test plan
- Reset with DEFAULT_WAIT=7, then read ch0 -> rdwr_ready low 8 cycles; diRegDataOut=0. A second read returns 1; a count-register read returns 2.
- Write wait[2]=0, read ch2 three times back-to-back -> ready low 1 cycle each; data 0,1,2.
- Write ch1=16'hFFFF (DATA_WIDTH=16), read ch1 twice -> 16'hFFFF then 16'h0000 (wrap).
- During a ch3 WAIT, pulse diRead on ch0 and change diRegAddr -> ignored. Ch3 completes with correct latency; ch0 count unchanged.
- Assert diReset mid-WAIT on ch1 (wait 5 written earlier) -> no increment; counts 0; wait[1] still 5. Repeat with resetb -> wait[1] back to 7.
- diEpAddr != EP_ADDR with read to address 0 -> diRegDataOut=0, rdwr_ready stays 1, no counter change. Unmapped address 2*NUM_CH+1 -> 0, count register unchanged.
